// File: rtl/booth_mult_seq.sv
// Sequential Booth multiplier, signed/unsigned W x W -> 2W, start/busy/done handshake.
// Define BOOTH_RADIX4_EN for radix-4 (modified Booth) recoding; default is radix-2.
module booth_mult_seq #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             tc,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [2*W-1:0]   prod,
    output logic             busy,
    output logic             done
);

`ifdef BOOTH_RADIX4_EN
    localparam int M  = ((W + 1) % 2 == 0) ? W + 1 : W + 2;
    localparam int N  = M / 2;
    localparam int AW = M + 2;
`else
    localparam int M  = W + 1;
    localparam int N  = M;
    localparam int AW = M + 1;
`endif
    localparam int RW = AW + M + 1;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt;
    logic [M-1:0]    mcand;
    logic [M-1:0]    q;
    logic            q1;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   mx;
    logic [AW-1:0]   sum;
    logic [RW-1:0]   shifted;
    logic            last;

    assign last = (cnt == CW'(N - 1));
    assign mx   = {{(AW - M){mcand[M-1]}}, mcand};
    assign busy = (state == CALC);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = CALC;
            CALC:    if (last) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

`ifdef BOOTH_RADIX4_EN
    always_comb begin
        sum = acc;
        unique case ({q[1:0], q1})
            3'b001, 3'b010: sum = acc + mx;
            3'b011:         sum = acc + (mx << 1);
            3'b100:         sum = acc - (mx << 1);
            3'b101, 3'b110: sum = acc - mx;
            default:        sum = acc;
        endcase
        shifted = {{2{sum[AW-1]}}, sum, q[M-1:1]};
    end
`else
    always_comb begin
        sum = acc;
        unique case ({q[0], q1})
            2'b01:   sum = acc + mx;
            2'b10:   sum = acc - mx;
            default: sum = acc;
        endcase
        shifted = {sum[AW-1], sum, q};
    end
`endif

    // shifted holds {acc, q, q-1} after this step; its low product bits sit above q-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand <= '0;
            q     <= '0;
            q1    <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            prod  <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    mcand <= {{(M - W){tc & a[W-1]}}, a};
                    q     <= {{(M - W){tc & b[W-1]}}, b};
                    q1    <= 1'b0;
                    acc   <= '0;
                    cnt   <= '0;
                end
                CALC: begin
                    acc <= shifted[RW-1 -: AW];
                    q   <= shifted[M:1];
                    q1  <= shifted[0];
                    cnt <= cnt + CW'(1);
                    if (last) prod <= shifted[2*W:1];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq (W=8): vector table plus handshake and reset sequences.
module tb_booth_mult_seq;

`ifdef BOOTH_RADIX4_EN
    localparam int N = 5;
`else
    localparam int N = 9;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        tc = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic [15:0] prod;
    logic        busy;
    logic        done;

    int pass_cnt = 0;
    int total = 0;

    booth_mult_seq #(.W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .tc(tc),
        .a(a), .b(b), .prod(prod), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        tc;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Accept at edge k, scramble inputs, then count edges until done.
    task automatic do_op(input logic t, input logic [7:0] x, input logic [7:0] y,
                         output int lat);
        @(negedge clk);
        start = 1'b1; tc = t; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); tc = ~t;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int done_n;
        int done_e[2];
        logic [15:0] p_seen[2];
        logic stable;
        logic both;
        logic [15:0] held;

        vecs[0]  = '{1'b0, 8'd200, 8'd150, 16'h7530};
        vecs[1]  = '{1'b1, 8'hFD,  8'h05,  16'hFFF1};
        vecs[2]  = '{1'b1, 8'h80,  8'h80,  16'h4000};
        vecs[3]  = '{1'b1, 8'h80,  8'h7F,  16'hC080};
        vecs[4]  = '{1'b0, 8'hFF,  8'hFF,  16'hFE01};
        vecs[5]  = '{1'b0, 8'h00,  8'h37,  16'h0000};
        vecs[6]  = '{1'b1, 8'hFF,  8'hFF,  16'h0001};
        vecs[7]  = '{1'b0, 8'h80,  8'h80,  16'h4000};
        vecs[8]  = '{1'b1, 8'h7F,  8'h7F,  16'h3F01};
        vecs[9]  = '{1'b0, 8'h0C,  8'h0A,  16'h0078};
        vecs[10] = '{1'b1, 8'h0C,  8'hF6,  16'hFF88};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_prod", 32'(prod), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].tc, vecs[i].a, vecs[i].b, lat);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(N));
            chk($sformatf("v%0d_prod", i), 32'(prod), 32'(vecs[i].exp));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'h0);
            held = prod;
            @(posedge clk); #1;
            chk($sformatf("v%0d_pulse", i), 32'(done), 32'h0);
            chk($sformatf("v%0d_hold", i), 32'(prod), 32'(held));
        end

        // start held high; only IDLE-sampled operands may be used
        done_n = 0;
        stable = 1'b1;
        both = 1'b0;
        for (int e = 0; e <= 2 * N + 3; e++) begin
            @(negedge clk);
            start = 1'b1; tc = 1'b0;
            a = 8'(e + 3); b = 8'(2 * e + 1);
            @(posedge clk); #1;
            if (busy && done) both = 1'b1;
            if (done) begin
                if (done_n < 2) begin
                    done_e[done_n] = e;
                    p_seen[done_n] = prod;
                end
                done_n++;
            end
            if (e > N && e < 2 * N + 2 && prod !== 16'd3) stable = 1'b0;
        end
        @(negedge clk);
        start = 1'b0;
        chk("hs_done_count", 32'(done_n), 32'd2);
        if (done_n >= 2) begin
            chk("hs_done1_edge", 32'(done_e[0]), 32'(N));
            chk("hs_done2_edge", 32'(done_e[1]), 32'(2 * N + 2));
            chk("hs_prod1", 32'(p_seen[0]), 32'd3);
            chk("hs_prod2", 32'(p_seen[1]), 32'((N + 5) * (2 * N + 5)));
        end
        chk("hs_prod_stable", 32'(stable), 32'h1);
        chk("hs_busy_done_excl", 32'(both), 32'h0);
        repeat (3) @(posedge clk);

        // asynchronous reset three cycles into an operation
        @(negedge clk);
        start = 1'b1; tc = 1'b0; a = 8'd9; b = 8'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("abort_busy_before", 32'(busy), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_prod", 32'(prod), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        done_n = 0;
        for (int e = 0; e < N + 3; e++) begin
            @(posedge clk); #1;
            if (done) done_n++;
        end
        chk("abort_no_done", 32'(done_n), 32'h0);
        do_op(1'b0, 8'd2, 8'd2, lat);
        chk("post_rst_lat", 32'(lat), 32'(N));
        chk("post_rst_prod", 32'(prod), 32'h0004);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
